mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: WAIT_MAX, 40, maximum WAIT-state cycles before timeout.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req0_valid / req1_valid  input  1 each  requester N presents an operation.
REQ-005 Port: req0_ready / req1_ready  output  1 each  arbiter accepts requester N this cycle.
REQ-006 Port: req0_x, req0_y / req1_x, req1_y  input  32 each  signed multiplicand and multiplier.
REQ-007 Port: rsp0_valid / rsp1_valid  output  1 each  result available for requester N.
REQ-008 Port: rsp0_ready / rsp1_ready  input  1 each  requester N takes the result.
REQ-009 Port: rsp0_p / rsp1_p  output  64 each  signed product for requester N.
REQ-010 Port: mul_in_valid  output  1  start pulse to the shared Booth multiplier.
REQ-011 Port: mul_x, mul_y  output  32 each  operands to the multiplier.
REQ-012 Port: mul_p  input  64  multiplier product.
REQ-013 Port: mul_out_valid  input  1  multiplier done (level, high while idle).
REQ-014 Port: busy  output  1  high when the state is not IDLE.
REQ-015 Port: err  output  1  sticky timeout flag.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-017 In IDLE with any reqN_valid, the arbiter SHALL grant one port by round-robin, preferring the port not granted last; if only one port is valid, that port wins.
REQ-018 reqN_ready SHALL be combinational: high only in IDLE for the granted port; transfer occurs on valid&&ready, operands are captured into internal registers, next state ISSUE.
REQ-019 The non-granted request SHALL wait without transfer; a requester may drop valid before acceptance with no effect.
REQ-020 In ISSUE, mul_in_valid SHALL be high for exactly one cycle; next state WAIT, wait counter cleared.
REQ-021 mul_x/mul_y SHALL equal the captured operands from ISSUE through the end of WAIT and SHALL be 0 otherwise.
REQ-022 In WAIT, mul_out_valid SHALL be ignored in the first WAIT cycle; thereafter mul_out_valid=1 captures mul_p into the result register, next state RESP.
REQ-023 With the 32-step multiplier, capture SHALL occur in the 33rd WAIT cycle; rspN_valid SHALL rise 35 cycles after the accept cycle.
REQ-024 If WAIT exceeds WAIT_MAX cycles without completion, err SHALL set, the result register SHALL be loaded with 0, next state RESP.
REQ-025 In RESP, rspN_valid SHALL be high only for the granted port; rspN_p SHALL hold stable until rspN_ready; on handshake, last-grant SHALL update, next state IDLE.
REQ-026 rspN_p of the non-granted port SHALL be 0; no new request SHALL be accepted outside IDLE.
REQ-027 Back-to-back operation SHALL sustain one operation per 36 cycles with rsp_ready held high.
REQ-028 Arithmetic SHALL be pass-through: the arbiter SHALL NOT modify operands or product.
REQ-029 err SHALL clear only on reset.

Reset
REQ-030 On rst_n low, the state SHALL be IDLE immediately, all outputs 0, err 0, operand/result registers 0, and last-grant SHALL be port 1 so port 0 wins the first tie.
REQ-031 Reset mid-operation SHALL abort the operation with no response; the multiplier shares rst_n.

Verification
REQ-032 Single op: req0 x=3, y=5 accepted cycle A -> rsp0_valid at A+35, rsp0_p=15, rsp1_valid never high.
REQ-033 Signed op: req1 x=0xFFFFFFFE, y=7 -> rsp1_p=0xFFFFFFFF_FFFFFFF2.
REQ-034 Contention: both valid continuously from reset -> grant order 0,1,0,1, each product correct, mul_in_valid one cycle per operation.
REQ-035 Backpressure: rsp0_ready low for 10 cycles in RESP -> rsp0_valid and rsp0_p stable, busy=1, req1_ready=0 throughout.
REQ-036 Timeout: model holds mul_out_valid low -> err=1 after WAIT_MAX+1 WAIT cycles, rspN_p=0, err stays high after the handshake.
REQ-037 Reset mid-WAIT: rst_n pulsed low -> all outputs 0 asynchronously; after release, req0 x=-1, y=-1 -> rsp0_p=1.

Source files
------------

// File: rtl/mul_arbiter.sv
//==============================================================================
// Module      : mul_arbiter
// Description : Round-robin arbiter sharing one sequential Booth multiplier
//               between two requesters, with a WAIT timeout and sticky err.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mul_arbiter #(
    parameter int WAIT_MAX = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_x,
    input  logic [31:0] req0_y,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_x,
    input  logic [31:0] req1_y,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [63:0] rsp0_p,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp1_p,
    output logic        mul_in_valid,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    input  logic [63:0] mul_p,
    input  logic        mul_out_valid,
    output logic        busy,
    output logic        err
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_q, last_d;
    logic               err_q, err_d;
    logic [31:0]        x_q, x_d;
    logic [31:0]        y_q, y_d;
    logic [63:0]        res_q, res_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;

    logic               w_pick;
    logic               w_idle;
    logic               w_rsp_hs;
    logic               w_op_phase;

    // Ties go to the port that was not served last; a lone request always wins.
    assign w_pick   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign w_idle   = (state_q == S_IDLE);
    assign w_rsp_hs = grant_q ? rsp1_ready : rsp0_ready;

    assign req0_ready = w_idle && req0_valid && !w_pick;
    assign req1_ready = w_idle && req1_valid &&  w_pick;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        err_d   = err_q;
        x_d     = x_q;
        y_d     = y_q;
        res_d   = res_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (req0_ready || req1_ready) begin
                    grant_d = w_pick;
                    x_d     = w_pick ? req1_x : req0_x;
                    y_d     = w_pick ? req1_y : req0_y;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // mul_out_valid is still the stale idle level in the first WAIT cycle.
                if ((wcnt_q != '0) && mul_out_valid) begin
                    res_d   = mul_p;
                    state_d = S_RESP;
                end else if (wcnt_q == CNT_W'(WAIT_MAX)) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = S_RESP;
                end else begin
                    wcnt_d  = wcnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (w_rsp_hs) begin
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            err_q   <= err_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign w_op_phase   = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign busy         = !w_idle;
    assign err          = err_q;
    assign mul_in_valid = (state_q == S_ISSUE);
    assign mul_x        = w_op_phase ? x_q : '0;
    assign mul_y        = w_op_phase ? y_q : '0;
    assign rsp0_valid   = (state_q == S_RESP) && !grant_q;
    assign rsp1_valid   = (state_q == S_RESP) &&  grant_q;
    assign rsp0_p       = rsp0_valid ? res_q : '0;
    assign rsp1_p       = rsp1_valid ? res_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_mul_arbiter.sv
//==============================================================================
// Module      : tb_mul_arbiter
// Description : Self-checking bench for mul_arbiter with a 32-step multiplier
//               model and a transaction-level timing model of the arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mul_arbiter;

    localparam int WAIT_MAX = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [63:0] rsp0_p, rsp1_p, mul_p;
    logic        mul_in_valid, mul_out_valid, busy, err;
    logic [31:0] mul_x, mul_y;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_p(rsp0_p),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_p(rsp1_p),
        .mul_in_valid(mul_in_valid), .mul_x(mul_x), .mul_y(mul_y),
        .mul_p(mul_p), .mul_out_valid(mul_out_valid),
        .busy(busy), .err(err)
    );

    // 32-step multiplier: done level drops for 32 cycles after a start pulse.
    logic [5:0]  m_cnt;
    logic [63:0] m_prod_reg;
    bit          mul_hang = 1'b0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt      <= '0;
            m_prod_reg <= '0;
        end else if (mul_in_valid) begin
            m_cnt      <= 6'd32;
            m_prod_reg <= $signed(mul_x) * $signed(mul_y);
        end else if (m_cnt != 0) begin
            m_cnt      <= m_cnt - 6'd1;
        end
    end
    assign mul_out_valid = (m_cnt == 0) && !mul_hang;
    assign mul_p         = m_prod_reg;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Transaction model: one op in flight, timing derived from its accept cycle.
    bit          m_busy = 0, m_last = 1, m_err = 0, m_hang = 0, m_port = 0;
    int          m_acc = 0;
    logic [31:0] m_x = '0, m_y = '0;
    logic [63:0] m_prod = '0;

    always @(negedge clk) begin
        int d, w;
        logic e_r0, e_r1, e_miv, e_v0, e_v1;
        logic [31:0] e_mx, e_my;
        logic [63:0] e_p0, e_p1;
        e_r0 = 0; e_r1 = 0; e_miv = 0; e_v0 = 0; e_v1 = 0;
        e_mx = '0; e_my = '0; e_p0 = '0; e_p1 = '0;
        d = 0; w = 0;
        if (!rst_n) begin
            m_busy = 0; m_last = 1; m_err = 0;
        end else if (!m_busy) begin
            e_r0 = req0_valid && (!req1_valid || m_last);
            e_r1 = req1_valid && (!req0_valid || !m_last);
        end else begin
            d = cyc - m_acc;
            w = m_hang ? WAIT_MAX + 1 : 33;
            e_miv = (d == 1);
            if (d >= 1 && d <= 1 + w) begin e_mx = m_x; e_my = m_y; end
            if (d >= 2 + w) begin
                if (m_hang) m_err = 1;
                if (m_port) begin e_v1 = 1; e_p1 = m_prod; end
                else        begin e_v0 = 1; e_p0 = m_prod; end
            end
        end
        chk("req0_ready", req0_ready, e_r0);
        chk("req1_ready", req1_ready, e_r1);
        chk("mul_in_valid", mul_in_valid, e_miv);
        chk("mul_x", mul_x, e_mx);
        chk("mul_y", mul_y, e_my);
        chk("rsp0_valid", rsp0_valid, e_v0);
        chk("rsp1_valid", rsp1_valid, e_v1);
        chk("rsp0_p", rsp0_p, e_p0);
        chk("rsp1_p", rsp1_p, e_p1);
        chk("busy", busy, rst_n && m_busy);
        chk("err", err, m_err);
        if (rst_n) begin
            if (!m_busy && (e_r0 || e_r1)) begin
                m_busy = 1; m_acc = cyc; m_port = e_r1; m_hang = mul_hang;
                m_x = e_r1 ? req1_x : req0_x;
                m_y = e_r1 ? req1_y : req0_y;
                m_prod = m_hang ? 64'd0 : longint'($signed(m_x)) * longint'($signed(m_y));
            end else if (m_busy && d >= 2 + w && (m_port ? rsp1_ready : rsp0_ready)) begin
                m_busy = 0; m_last = m_port;
            end
        end
    end

    task automatic wait_accept(input bit port, output int acc);
        bit got = 0;
        acc = -1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (port ? req1_ready : req0_ready) begin got = 1; acc = cyc; end
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (port) req1_valid = 0; else req0_valid = 0;
    endtask

    task automatic wait_rsp(input bit port, output int at, output logic [63:0] p);
        bit got = 0;
        at = -1; p = '0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (port ? rsp1_valid : rsp0_valid) begin
                got = 1; at = cyc; p = port ? rsp1_p : rsp0_p;
            end
        end
        if (!got) chk("rsp_timeout", 0, 1);
    endtask

    task automatic single_op(input bit port, input logic [31:0] x, input logic [31:0] y,
                             input logic [63:0] exp_p, input int exp_lat);
        int a, r;
        logic [63:0] p;
        if (port) begin req1_x = x; req1_y = y; req1_valid = 1; end
        else      begin req0_x = x; req0_y = y; req0_valid = 1; end
        wait_accept(port, a);
        wait_rsp(port, r, p);
        chk("latency", 64'(r - a), 64'(exp_lat));
        chk("product", p, exp_p);
        @(posedge clk); #1;
    endtask

    initial begin
        int q_port[$];
        int q_cyc[$];
        int a, r;
        logic [63:0] p, p_hold;

        #1 rst_n = 0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_err", err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        single_op(0, 32'd3, 32'd5, 64'd15, 35);
        single_op(1, 32'hFFFF_FFFE, 32'd7, 64'hFFFF_FFFF_FFFF_FFF2, 35);

        // Contention: both ports valid continuously.
        req0_x = 32'd7;      req0_y = 32'hFFFF_FFFD;
        req1_x = 32'd100000; req1_y = 32'd300000;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 400 && q_port.size() < 4; i++) begin
            @(negedge clk);
            if (req0_ready) begin q_port.push_back(0); q_cyc.push_back(cyc); end
            if (req1_ready) begin q_port.push_back(1); q_cyc.push_back(cyc); end
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        chk("contention_count", 64'(q_port.size()), 64'd4);
        if (q_port.size() == 4) begin
            chk("grant_0", 64'(q_port[0]), 64'd0);
            chk("grant_1", 64'(q_port[1]), 64'd1);
            chk("grant_2", 64'(q_port[2]), 64'd0);
            chk("grant_3", 64'(q_port[3]), 64'd1);
            for (int i = 1; i < 4; i++)
                chk("op_period", 64'(q_cyc[i] - q_cyc[i-1]), 64'd36);
        end
        wait_rsp(1, r, p);
        chk("contention_p1", p, 64'd30000000000);
        @(posedge clk); #1;

        // Backpressure on port 0 while port 1 waits.
        rsp0_ready = 0;
        req0_x = 32'd11; req0_y = 32'd13; req0_valid = 1;
        wait_accept(0, a);
        req1_x = 32'd2; req1_y = 32'd3; req1_valid = 1;
        wait_rsp(0, r, p_hold);
        chk("bp_p", p_hold, 64'd143);
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", rsp0_valid, 1);
            chk("bp_stable", rsp0_p, p_hold);
            chk("bp_busy", busy, 1);
            chk("bp_req1_ready", req1_ready, 0);
        end
        @(posedge clk); #1;
        rsp0_ready = 1;
        wait_accept(1, a);
        wait_rsp(1, r, p);
        chk("bp_p1", p, 64'd6);
        @(posedge clk); #1;

        // Timeout with a multiplier that never completes.
        mul_hang = 1;
        single_op(0, 32'd9, 32'd9, 64'd0, WAIT_MAX + 3);
        mul_hang = 0;
        @(negedge clk);
        chk("err_sticky", err, 1);
        @(posedge clk); #1;

        // Reset mid-WAIT.
        req0_x = 32'd5; req0_y = 32'd5; req0_valid = 1;
        wait_accept(0, a);
        repeat (10) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_mul_x", mul_x, 0);
        chk("arst_err", err, 0);
        chk("arst_rsp0_valid", rsp0_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        single_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 35);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
